dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_array.sv | 19 +
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, doubleword offset width and index-width helper
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int DW_OFFSET_BITS = 3;
  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 64 store, sync write, sync read-before-write, no reset
//   i_clk clock; i_we write enable; i_re read enable; i_addr doubleword index;
//   i_wdata write data; o_rdata registered read data (held while i_re is low)
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic                       i_re,
  input  logic [idx_bits(DEPTH)-1:0] i_addr,
  input  logic [63:0]                i_wdata,
  output logic [63:0]                o_rdata
);
  logic [63:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked fixed-latency 64-bit doubleword data memory for the MEM stage
//   CLK/reset: clock, async active-high reset
//   req_valid/req_ready/req_write/req_addr/req_wdata: request channel (byte address)
//   resp_valid/resp_ready/resp_rdata/resp_err: response channel
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW = idx_bits(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);
  state_t r_state;
  logic [3:0] r_cnt;
  logic r_write, r_ready, r_valid, r_err, r_ld;
  logic [63:0] r_addr, r_wdata;
  logic w_accept, w_exec, w_write, w_err;
  logic [63:0] w_addr, w_wdata, w_rdata;
  logic [IW-1:0] w_idx;
  assign w_accept = (r_state == IDLE) && req_valid;
  // With LATENCY=1 the access executes on the accept edge itself, straight from the request inputs
  assign w_exec  = (LATENCY == 1) ? w_accept : (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_write = (LATENCY == 1) ? req_write : r_write;
  assign w_addr  = (LATENCY == 1) ? req_addr : r_addr;
  assign w_wdata = (LATENCY == 1) ? req_wdata : r_wdata;
  assign w_idx   = w_addr[DW_OFFSET_BITS +: IW];
  assign w_err   = (|w_addr[DW_OFFSET_BITS-1:0]) || (|w_addr[63:DW_OFFSET_BITS+IW]);
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .i_clk  (CLK),
    .i_we   (w_exec && w_write && !w_err),
    .i_re   (w_exec && !w_write && !w_err),
    .i_addr (w_idx),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  // The array's read register only updates on a load, so it is stable through RESP;
  // r_ld gates it to zero for stores, errors, idle and after reset.
  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign resp_err   = r_err;
  assign resp_rdata = r_ld ? w_rdata : 64'd0;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_ready <= 1'b0;
          r_cnt   <= CNT_INIT;
          if (LATENCY == 1) r_state <= RESP;
          else r_state <= BUSY;
        end
        BUSY: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else r_cnt <= r_cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_ld    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_exec) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_ld    <= !w_write && !w_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responder builds (LATENCY 2, 1, 15)
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        vld [3];
  logic        wr  [3];
  logic        rdy [3];
  logic [63:0] addr[3];
  logic [63:0] wd  [3];
  logic        qr  [3];
  logic        pv  [3];
  logic        err [3];
  logic [63:0] rd  [3];
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH(256), .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .CLK       (clk),
      .reset     (rst),
      .req_valid (vld[g]),
      .req_ready (qr[g]),
      .req_write (wr[g]),
      .req_addr  (addr[g]),
      .req_wdata (wd[g]),
      .resp_valid(pv[g]),
      .resp_ready(rdy[g]),
      .resp_rdata(rd[g]),
      .resp_err  (err[g])
    );
  end
  task automatic do_req(input int k, input logic w, input logic [63:0] a, input logic [63:0] d,
                        output int lat, output logic [63:0] r, output logic e);
    @(posedge clk); #1;
    vld[k] = 1'b1; wr[k] = w; addr[k] = a; wd[k] = d;
    @(posedge clk); #1;
    vld[k] = 1'b0; wr[k] = ~w; addr[k] = ~a; wd[k] = ~d;
    lat = 1;
    while (!pv[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = rd[k];
    e = err[k];
    if (pv[k]) begin
      rdy[k] = 1'b1;
      @(posedge clk); #1;
      rdy[k] = 1'b0;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (qr[0] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", qr[0]); end
    n_tests++; if (pv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", pv[0]); end
    n_tests++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b want 0", err[0]); end
    n_tests++; if (rd[0] !== 64'd0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", rd[0]); end
    rst = 1'b0;
  endtask
  task automatic test_store_load;
    int lat; logic [63:0] r; logic e;
    do_req(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, lat, r, e);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL st_latency got %0d want 2", lat); end
    n_tests++; if (r !== 64'd0) begin n_fail++; $display("FAIL st_rdata got %h want 0", r); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL st_err got %b want 0", e); end
    n_tests++; if (qr[0] !== 1'b1) begin n_fail++; $display("FAIL st_ready_after got %b want 1", qr[0]); end
    do_req(0, 1'b0, 64'h10, 64'h0, lat, r, e);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ld_latency got %0d want 2", lat); end
    n_tests++; if (r !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL ld_rdata got %h want deadbeefcafef00d", r); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", e); end
  endtask
  task automatic test_errors;
    int lat; logic [63:0] r; logic e;
    do_req(0, 1'b1, 64'h0, 64'h5555, lat, r, e);
    do_req(0, 1'b0, 64'h13, 64'h0, lat, r, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b want 1", e); end
    n_tests++; if (r !== 64'd0) begin n_fail++; $display("FAIL misalign_rdata got %h want 0", r); end
    do_req(0, 1'b1, 64'h800, 64'h9999, lat, r, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_store_err got %b want 1", e); end
    do_req(0, 1'b0, 64'h0, 64'h0, lat, r, e);
    n_tests++; if (r !== 64'h5555) begin n_fail++; $display("FAIL oor_no_alias got %h want 5555", r); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL addr0_err got %b want 0", e); end
    do_req(0, 1'b0, 64'h8000_0000_0000_0010, 64'h0, lat, r, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL high_bit_err got %b want 1", e); end
  endtask
  task automatic test_backpressure;
    @(posedge clk); #1;
    vld[0] = 1'b1; wr[0] = 1'b0; addr[0] = 64'h10;
    @(posedge clk); #1;
    addr[0] = 64'h0;
    @(posedge clk); #1;
    n_tests++; if (pv[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise got %b want 1", pv[0]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++; if (pv[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, pv[0]); end
      n_tests++; if (rd[0] !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL bp_hold_rdata[%0d] got %h want deadbeefcafef00d", i, rd[0]); end
      n_tests++; if (qr[0] !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, qr[0]); end
    end
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0; vld[0] = 1'b0;
    n_tests++; if (pv[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", pv[0]); end
    n_tests++; if (qr[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", qr[0]); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++; if (pv[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept[%0d] got %b want 0", i, pv[0]); end
    end
  endtask
  task automatic test_latency(input int k, input int want);
    int lat; logic [63:0] r; logic e;
    for (int i = 0; i < 20; i++) begin
      do_req(k, 1'b0, 64'(i * 8), 64'h0, lat, r, e);
      n_tests++; if (lat !== want) begin n_fail++; $display("FAIL lat%0d_load[%0d] got %0d want %0d", want, i, lat, want); end
    end
    do_req(k, 1'b1, 64'h98, 64'h0123_4567_89AB_CDEF, lat, r, e);
    do_req(k, 1'b0, 64'h98, 64'h0, lat, r, e);
    n_tests++; if (r !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL lat%0d_data got %h want 0123456789abcdef", want, r); end
  endtask
  task automatic test_reset_busy;
    int lat; logic [63:0] r; logic e;
    do_req(0, 1'b1, 64'h20, 64'h2222, lat, r, e);
    @(posedge clk); #1;
    vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 64'h20; wd[0] = 64'h1111;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (pv[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy_valid got %b want 0", pv[0]); end
    n_tests++; if (qr[0] !== 1'b1) begin n_fail++; $display("FAIL rst_busy_ready got %b want 1", qr[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 1'b0, 64'h20, 64'h0, lat, r, e);
    n_tests++; if (r !== 64'h2222) begin n_fail++; $display("FAIL rst_busy_dropped got %h want 2222", r); end
  endtask
  task automatic test_reset_resp;
    @(posedge clk); #1;
    vld[0] = 1'b1; wr[0] = 1'b0; addr[0] = 64'h10;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (pv[0] !== 1'b1) begin n_fail++; $display("FAIL rst_resp_pre got %b want 1", pv[0]); end
    rst = 1'b1;
    #1;
    n_tests++; if (pv[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", pv[0]); end
    n_tests++; if (rd[0] !== 64'd0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", rd[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_boundary;
    int lat; logic [63:0] r; logic e;
    do_req(0, 1'b1, 64'h7F8, 64'hA5A5_5A5A_F0F0_0F0F, lat, r, e);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL top_store_err got %b want 0", e); end
    do_req(0, 1'b0, 64'h7F8, 64'h0, lat, r, e);
    n_tests++; if (r !== 64'hA5A5_5A5A_F0F0_0F0F) begin n_fail++; $display("FAIL top_load got %h want a5a55a5af0f00f0f", r); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL top_load_err got %b want 0", e); end
    do_req(0, 1'b0, 64'h800, 64'h0, lat, r, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL past_top_err got %b want 1", e); end
    n_tests++; if (r !== 64'd0) begin n_fail++; $display("FAIL past_top_rdata got %h want 0", r); end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; wr[i] = 1'b0; rdy[i] = 1'b0; addr[i] = 64'd0; wd[i] = 64'd0;
    end
    test_reset;
    test_store_load;
    test_errors;
    test_backpressure;
    test_latency(1, 1);
    test_latency(2, 15);
    test_reset_busy;
    test_reset_resp;
    test_boundary;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
